// File: rtl/viterbi_pkg.sv
// Shared constants, types and helpers for the K=3, rate-1/2 (7,5) Viterbi decoder.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int K          = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    // Trellis state {b1, b2}, b1 is the most recent input bit.
    typedef logic [1:0] state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACS,
        S_TRACE
    } fsm_t;

    // Encoder output {c0, c1} when input u enters from state prev.
    function automatic logic [1:0] expected_sym(state_t prev, logic u);
        logic [K-1:0] taps;
        taps = {u, prev};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

    // Hamming distance between two 2-bit symbols (0..2).
    function automatic logic [1:0] hamming2(logic [1:0] a, logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// One add-compare-select node: saturating adds of two candidate paths, keep the smaller.
module viterbi_acs_unit #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] m0;
    logic [PM_W-1:0] m1;

    // Saturating candidate metrics; ties resolve to the p0 branch.
    always_comb begin
        sum0   = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
        sum1   = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
        m0     = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
        m1     = sum1[PM_W] ? '1 : sum1[PM_W-1:0];
        dec    = (m1 < m0);
        pm_new = dec ? m1 : m0;
    end

endmodule

// File: rtl/viterbi_acs_traceback.sv
// Hard-decision Viterbi core: per-symbol ACS over 4 states, then serial traceback of one frame.
module viterbi_acs_traceback
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int PM_W      = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sym_valid,
    input  logic [1:0]           i_sym,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic [FRAME_LEN-1:0] o_data,
    output logic                 o_valid
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN - 1);
    localparam logic [PM_W-1:0]  PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

    fsm_t                  state_q, state_d;
    logic [PM_W-1:0]       pm_q   [NUM_STATES];
    logic [PM_W-1:0]       pm_new [NUM_STATES];
    logic [NUM_STATES-1:0] dec_new;
    logic [NUM_STATES-1:0] surv_q [FRAME_LEN];
    logic [CNT_W-1:0]      sym_cnt_q;
    logic [CNT_W-1:0]      trace_cnt_q;
    logic [CNT_W-1:0]      t_idx;
    state_t                tb_state_q;
    state_t                best_state;
    state_t                cur_state;
    logic [PM_W-1:0]       best_pm;
    logic [FRAME_LEN-2:0]  bits_q;
    logic                  accept;
    logic                  trace_last;
    logic                  surv_bit;

    assign o_ready    = (state_q != S_TRACE);
    assign o_busy     = (state_q != S_IDLE);
    assign accept     = i_sym_valid & o_ready;
    assign trace_last = (state_q == S_TRACE) && (trace_cnt_q == LAST);

    // Four ACS nodes; next state ns has predecessors {ns[0],0} and {ns[0],1} with input ns[1].
    for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
        localparam state_t P0 = state_t'((ns % 2) * 2);
        localparam state_t P1 = state_t'((ns % 2) * 2 + 1);
        localparam logic   U  = 1'(ns / 2);
        logic [1:0] bm0;
        logic [1:0] bm1;
        assign bm0 = hamming2(i_sym, expected_sym(P0, U));
        assign bm1 = hamming2(i_sym, expected_sym(P1, U));
        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0    (pm_q[P0]),
            .pm1    (pm_q[P1]),
            .bm0    (bm0),
            .bm1    (bm1),
            .pm_new (pm_new[ns]),
            .dec    (dec_new[ns])
        );
    end

    // Traceback start state: smallest path metric, lowest index on ties.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        best_state = '0;
        best_pm    = pm_q[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (pm_q[s] < best_pm) begin
                best_pm    = pm_q[s];
                best_state = state_t'(s);
            end
        end
    end

    assign cur_state = (trace_cnt_q == '0) ? best_state : tb_state_q;
    assign t_idx     = LAST - trace_cnt_q;
    assign surv_bit  = surv_q[t_idx][cur_state];

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state: frame of accepted symbols, then FRAME_LEN traceback cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ACS: if (accept) state_d = (sym_cnt_q == LAST) ? S_TRACE : S_ACS;
            S_TRACE:       if (trace_cnt_q == LAST) state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Path metrics, counters, traceback walk and decoded-word output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pm_q[0]     <= '0;
            for (int s = 1; s < NUM_STATES; s++) pm_q[s] <= PM_INIT;
            sym_cnt_q   <= '0;
            trace_cnt_q <= '0;
            tb_state_q  <= '0;
            bits_q      <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
        end else begin
            o_valid <= trace_last;
            if (accept) begin
                pm_q      <= pm_new;
                sym_cnt_q <= (sym_cnt_q == LAST) ? '0 : sym_cnt_q + 1'b1;
            end else if (trace_last) begin
                pm_q[0] <= '0;
                for (int s = 1; s < NUM_STATES; s++) pm_q[s] <= PM_INIT;
            end
            if (state_q == S_TRACE) begin
                trace_cnt_q <= trace_last ? '0 : trace_cnt_q + 1'b1;
                tb_state_q  <= {cur_state[0], surv_bit};
                bits_q      <= {cur_state[1], bits_q[FRAME_LEN-2:1]};
                if (trace_last) o_data <= {cur_state[1], bits_q};
            end
        end
    end

    // Survivor store: one decision bit per state per step, overwritten by the next frame.
    always_ff @(posedge i_clk) begin
        // NOTE: the survivor store has no reset; every entry is written before traceback reads it.
        if (accept) surv_q[sym_cnt_q] <= dec_new;
    end

endmodule

// File: tb/tb_viterbi_acs_traceback.sv
// Directed and random-frame bench for the Viterbi ACS/traceback core.
module tb_viterbi_acs_traceback;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_sym_valid;
    logic [1:0] i_sym;
    logic       o_ready;
    logic       o_busy;
    logic [7:0] o_data;
    logic       o_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    viterbi_acs_traceback #(.FRAME_LEN(8), .PM_W(6)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_sym_valid (i_sym_valid),
        .i_sym       (i_sym),
        .o_ready     (o_ready),
        .o_busy      (o_busy),
        .o_data      (o_data),
        .o_valid     (o_valid)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (o_valid === 1'b1) n_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [1:0] s);
        @(negedge i_clk);
        i_sym_valid = v;
        i_sym       = s;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] w, input int gap);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, w[15-2*i -: 2]);
            if (i < 7) repeat (gap) cyc(1'b0, 2'b11);
        end
    endtask

    // Count rising edges until o_valid shows, bounded at 40.
    task automatic wait_valid(input logic hv, input logic [1:0] hs, output int n);
        @(negedge i_clk);
        i_sym_valid = hv;
        i_sym       = hs;
        n = 0;
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while (o_valid !== 1'b1 && n < 40);
    endtask

    function automatic logic [15:0] encode(input logic [7:0] word);
        logic [15:0] out;
        logic b1, b2, u;
        b1 = 1'b0; b2 = 1'b0; out = '0;
        for (int i = 0; i < 8; i++) begin
            u = word[7-i];
            out[15-2*i -: 2] = {u ^ b1 ^ b2, u ^ b2};
            b2 = b1;
            b1 = u;
        end
        return out;
    endfunction

    // Register-exchange reference decoder: each state carries its full surviving bit history.
    function automatic logic [7:0] ref_decode(input logic [15:0] rx);
        int pm [4];
        int npm [4];
        logic [7:0] path [4];
        logic [7:0] npath [4];
        logic [1:0] s;
        int p0, p1, u, m0, m1, c0, c1, best;
        pm = '{0, 16, 16, 16};
        for (int k = 0; k < 4; k++) path[k] = '0;
        for (int t = 0; t < 8; t++) begin
            s = rx[15-2*t -: 2];
            for (int ns = 0; ns < 4; ns++) begin
                p0 = (ns % 2) * 2;
                p1 = p0 + 1;
                u  = ns / 2;
                c0 = u ^ (p0 >> 1) ^ (p0 & 1);
                c1 = u ^ (p0 & 1);
                m0 = pm[p0] + (int'(s[1]) ^ c0) + (int'(s[0]) ^ c1);
                c0 = u ^ (p1 >> 1) ^ (p1 & 1);
                c1 = u ^ (p1 & 1);
                m1 = pm[p1] + (int'(s[1]) ^ c0) + (int'(s[0]) ^ c1);
                if (m0 > 63) m0 = 63;
                if (m1 > 63) m1 = 63;
                if (m1 < m0) begin
                    npm[ns]   = m1;
                    npath[ns] = {path[p1][6:0], 1'(u)};
                end else begin
                    npm[ns]   = m0;
                    npath[ns] = {path[p0][6:0], 1'(u)};
                end
            end
            pm   = npm;
            path = npath;
        end
        best = 0;
        for (int k = 1; k < 4; k++) if (pm[k] < pm[best]) best = k;
        return path[best];
    endfunction

    initial begin
        int n;
        int pulses_before;
        logic [7:0]  word;
        logic [15:0] enc;
        logic [15:0] rx;
        logic [7:0]  exp_data;

        i_rst_n     = 1'b0;
        i_sym_valid = 1'b0;
        i_sym       = 2'b00;

        // Reset state
        #3;
        chk("rst_o_data", o_data, 8'h00);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_busy", o_busy, 1'b0);
        chk("rst_o_ready", o_ready, 1'b1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // 1: all-zero frame, latency and one-cycle pulse
        send_frame(16'h0000, 0);
        wait_valid(1'b0, 2'b00, n);
        chk("t1_latency", n, 8);
        chk("t1_data", o_data, 8'h00);
        cyc(1'b0, 2'b00);
        chk("t1_pulse_width", o_valid, 1'b0);
        chk("t1_idle_busy", o_busy, 1'b0);

        // 2: clean encoded 8'hB4
        send_frame(16'hE14B, 0);
        chk("t2_trace_ready", o_ready, 1'b0);
        chk("t2_trace_busy", o_busy, 1'b1);
        wait_valid(1'b0, 2'b00, n);
        chk("t2_latency", n, 8);
        chk("t2_data", o_data, 8'hB4);
        cyc(1'b0, 2'b00);
        chk("t2_data_held", o_data, 8'hB4);

        // 3: symbol 2 corrupted 00 -> 10
        send_frame(16'hE94B, 0);
        wait_valid(1'b0, 2'b00, n);
        chk("t3_latency", n, 8);
        chk("t3_data", o_data, 8'hB4);

        // 5: reset after the 4th symbol, then again mid-trace, then a clean frame
        for (int i = 0; i < 4; i++) cyc(1'b1, enc_sym(16'hE14B, i));
        chk("t5_busy_before_rst", o_busy, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", o_busy, 1'b0);
        chk("t5_rst_ready", o_ready, 1'b1);
        chk("t5_rst_data", o_data, 8'h00);
        @(negedge i_clk);
        i_sym_valid = 1'b0;
        i_rst_n     = 1'b1;
        pulses_before = n_pulses;
        send_frame(16'hE14B, 0);
        repeat (3) cyc(1'b0, 2'b00);
        i_rst_n = 1'b0;
        #1;
        chk("t5_trace_rst_busy", o_busy, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (12) cyc(1'b0, 2'b00);
        chk("t5_no_spurious_valid", n_pulses, pulses_before);
        send_frame(16'hE14B, 0);
        wait_valid(1'b0, 2'b00, n);
        chk("t5_latency", n, 8);
        chk("t5_data", o_data, 8'hB4);

        // 4: gaps in ACS, valid held through TRACE, back-to-back zero frame
        send_frame(16'hE14B, 2);
        wait_valid(1'b1, 2'b11, n);
        chk("t4_latency", n, 8);
        chk("t4_data", o_data, 8'hB4);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 2'b00);
            if (i == 0) begin
                chk("t4_pulse_width", o_valid, 1'b0);
                chk("t4_busy_b2b", o_busy, 1'b1);
            end
        end
        wait_valid(1'b0, 2'b00, n);
        chk("t4_b2b_latency", n, 8);
        chk("t4_b2b_data", o_data, 8'h00);

        // 6: random words with 0-1 bit errors against the reference decoder
        for (int f = 0; f < 1000; f++) begin
            word = 8'($urandom);
            enc  = encode(word);
            rx   = enc;
            if ($urandom_range(0, 1) == 1) rx[$urandom_range(0, 15)] ^= 1'b1;
            exp_data = ref_decode(rx);
            send_frame(rx, 0);
            wait_valid(1'b0, 2'b00, n);
            chk("t6_latency", n, 8);
            chk("t6_data", o_data, exp_data);
            if (rx == enc) chk("t6_clean_word", o_data, word);
        end

        cyc(1'b0, 2'b00);
        chk("total_valid_pulses", n_pulses, 1006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic [1:0] enc_sym(input logic [15:0] w, input int i);
        return w[15-2*i -: 2];
    endfunction

endmodule
